// File: rtl/output_port_scheduler_pkg.sv
// Shared router globals and scheduler state encoding.
package output_port_scheduler_pkg;

    localparam int PORT_N      = 0;
    localparam int PORT_S      = 1;
    localparam int PORT_E      = 2;
    localparam int PORT_W      = 3;
    localparam int PORT_CACHE  = 4;

    localparam int OUT_CREDITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_NO_CREDIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_pick #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Scan upward from ptr, wrapping at N, and keep the first hit.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port round-robin scheduler with burst hold and downstream credits.
//   state        | meaning
//   ST_IDLE      | no request, no grant
//   ST_GRANT     | grant_valid high, a flit moves this cycle
//   ST_NO_CREDIT | requests pending but downstream buffer full
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 5,
    parameter int CREDITS   = OUT_CREDITS,
    parameter int CREDIT_W  = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  lock,
    input  logic                credit_return,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [NUM_REQ-1:0]  stall,
    output logic [CREDIT_W-1:0] credit_count,
    output logic                credit_overflow
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST) + 1;

    sched_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                ovf_q, ovf_d;

    logic [NUM_REQ-1:0]  pick_winner;
    logic                pick_valid;
    logic [PTR_W-1:0]    cur_idx, win_idx;
    logic [CREDIT_W:0]   eff_credit, credit_sum;
    logic                hold;
    logic                gv_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Index of the current grantee and of the round-robin winner.
    always_comb begin
        cur_idx = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i])     cur_idx = PTR_W'(i);
            if (pick_winner[i]) win_idx = PTR_W'(i);
        end
    end

    // Next state, grant, pointer, burst and credit computation.
    always_comb begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        ptr_d      = ptr_q;
        burst_d    = '0;
        gv_d       = 1'b0;
        // A same-edge return counts toward the credit available for granting.
        eff_credit = {1'b0, credit_q} + {{CREDIT_W{1'b0}}, credit_return};
        hold       = (state_q == ST_GRANT) && req[cur_idx] && lock[cur_idx] &&
                     (burst_q < BURST_W'(MAX_BURST-1)) && (eff_credit != '0);

        if (pick_valid) begin
            if (eff_credit == '0) begin
                state_d = ST_NO_CREDIT;
            end else begin
                state_d = ST_GRANT;
                gv_d    = 1'b1;
                if (hold) begin
                    grant_d = grant_q;
                    burst_d = burst_q + 1'b1;
                    ptr_d   = next_ptr(cur_idx);
                end else begin
                    grant_d = pick_winner;
                    ptr_d   = next_ptr(win_idx);
                end
            end
        end

        credit_sum = eff_credit - {{CREDIT_W{1'b0}}, gv_d};
        credit_d   = (credit_sum > (CREDIT_W+1)'(CREDITS)) ? CREDIT_W'(CREDITS)
                                                            : credit_sum[CREDIT_W-1:0];
        ovf_d      = ovf_q | (credit_return && (credit_q == CREDIT_W'(CREDITS)));
    end

    // State registers update on the falling edge like the rest of the fabric.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            burst_q  <= '0;
            credit_q <= CREDIT_W'(CREDITS);
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            burst_q  <= burst_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign grant           = grant_q;
    assign grant_valid     = (state_q == ST_GRANT);
    assign stall           = req & ~(grant_q & {NUM_REQ{grant_valid}});
    assign credit_count    = credit_q;
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: spec-level model plus literal spot checks.
module tb_output_port_scheduler;
    import output_port_scheduler_pkg::*;

    localparam int NR = 5;
    localparam int CR = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req, lock;
    logic       credit_return;
    logic [4:0] grant, stall;
    logic       grant_valid;
    logic [2:0] credit_count;
    logic       credit_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_gi, m_ptr, m_burst, m_credit;
    bit m_gv, m_ovf;
    bit chk_en = 1'b0;

    output_port_scheduler #(
        .NUM_REQ(NR), .CREDITS(CR), .CREDIT_W(3), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .credit_return(credit_return), .grant(grant), .grant_valid(grant_valid),
        .stall(stall), .credit_count(credit_count), .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [4:0] v, input int i);
        return v[3'(i)];
    endfunction

    task automatic model_reset();
        m_gv = 0; m_gi = 0; m_ptr = 0; m_burst = 0; m_credit = CR; m_ovf = 0;
    endtask

    task automatic model_step();
        int  eff, w;
        bit  hold;
        eff  = m_credit + (credit_return ? 1 : 0);
        hold = m_gv && bit_at(req, m_gi) && bit_at(lock, m_gi) && (m_burst < MB-1) && (eff > 0);
        if (credit_return && m_credit == CR) m_ovf = 1;
        if (req == 5'd0 || eff == 0) begin
            m_gv    = 0;
            m_burst = 0;
        end else begin
            if (hold) begin
                m_burst++;
            end else begin
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && bit_at(req, (m_ptr + k) % NR)) w = (m_ptr + k) % NR;
                m_gi    = w;
                m_burst = 0;
            end
            m_gv  = 1;
            m_ptr = (m_gi + 1) % NR;
        end
        m_credit = eff - (m_gv ? 1 : 0);
        if (m_credit > CR) m_credit = CR;
    endtask

    // Model advances on the same falling edge as the design.
    always @(negedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    function automatic logic [4:0] exp_grant();
        return m_gv ? 5'(1 << m_gi) : 5'd0;
    endfunction

    // Compare every cycle, midway between falling edges.
    always @(posedge clk) begin
        if (chk_en) begin
            chk("grant",           32'(grant),           32'(exp_grant()));
            chk("grant_valid",     32'(grant_valid),     32'(m_gv));
            chk("stall",           32'(stall),           32'(req & ~exp_grant()));
            chk("credit_count",    32'(credit_count),    32'(m_credit));
            chk("credit_overflow", 32'(credit_overflow), 32'(m_ovf));
        end
    end

    task automatic tick(input logic [4:0] r, input logic [4:0] l, input logic ret);
        req = r; lock = l; credit_return = ret;
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    logic [4:0] exp_seq [4];
    logic [4:0] burst_seq [6];
    logic [4:0] tbl_req [12];
    logic [4:0] tbl_lock [12];
    logic       tbl_ret [12];

    initial begin
        reset = 1'b0; req = '0; lock = '0; credit_return = 1'b0;
        @(negedge clk);
        #2;
        req = 5'b00011;
        #1;
        chk("rst_grant",  32'(grant),           32'd0);
        chk("rst_gv",     32'(grant_valid),     32'd0);
        chk("rst_credit", 32'(credit_count),    32'd4);
        chk("rst_ovf",    32'(credit_overflow), 32'd0);
        chk("rst_stall",  32'(stall),           32'h03);
        chk_en = 1'b1;
        reset  = 1'b1;

        // single N request, then N+S shows ptr moved to 1
        tick(5'b00001, 5'b0, 1'b0);
        chk("t1_grant",  32'(grant),        32'h01);
        chk("t1_gv",     32'(grant_valid),  32'd1);
        chk("t1_credit", 32'(credit_count), 32'd3);
        tick(5'b00011, 5'b0, 1'b0);
        chk("t1_ptr1",   32'(grant),        32'h02);

        // all request, credits run out after four grants
        do_reset();
        exp_seq[0] = 5'b00001; exp_seq[1] = 5'b00010;
        exp_seq[2] = 5'b00100; exp_seq[3] = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            tick(5'b11111, 5'b0, 1'b0);
            chk("t2_grant",  32'(grant),        32'(exp_seq[i]));
            chk("t2_credit", 32'(credit_count), 32'(3 - i));
        end
        chk("t2_stall4", 32'(stall), 32'h17);
        tick(5'b11111, 5'b0, 1'b0);
        chk("t2_nc_grant", 32'(grant),       32'd0);
        chk("t2_nc_gv",    32'(grant_valid), 32'd0);
        chk("t2_nc_stall", 32'(stall),       32'h1f);

        // same-edge return unblocks cache grant
        tick(5'b10000, 5'b0, 1'b1);
        chk("t3_grant",  32'(grant),        32'h10);
        chk("t3_credit", 32'(credit_count), 32'd0);

        // burst hold limited to MAX_BURST
        do_reset();
        burst_seq[0] = 5'b00001; burst_seq[1] = 5'b00001; burst_seq[2] = 5'b00001;
        burst_seq[3] = 5'b00001; burst_seq[4] = 5'b00100; burst_seq[5] = 5'b00001;
        for (int i = 0; i < 6; i++) begin
            tick(5'b00101, 5'b00001, 1'b1);
            chk("t4_burst", 32'(grant), 32'(burst_seq[i]));
        end

        // return at full credit is sticky overflow
        do_reset();
        tick(5'b0, 5'b0, 1'b1);
        chk("t5_credit", 32'(credit_count),    32'd4);
        chk("t5_ovf",    32'(credit_overflow), 32'd1);
        tick(5'b0, 5'b0, 1'b0);
        chk("t5_sticky", 32'(credit_overflow), 32'd1);

        // asynchronous reset mid-burst
        do_reset();
        tick(5'b00001, 5'b00001, 1'b0);
        tick(5'b00001, 5'b00001, 1'b0);
        chk("t6_pre", 32'(grant), 32'h01);
        reset = 1'b0;
        #1;
        chk("t6_grant",  32'(grant),        32'd0);
        chk("t6_credit", 32'(credit_count), 32'd4);
        chk("t6_stall",  32'(stall),        32'h01);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(5'b00011, 5'b0, 1'b0);
        chk("t6_ptr0", 32'(grant), 32'h01);

        // mixed directed vectors, checked by the model
        do_reset();
        tbl_req[0]  = 5'b00100; tbl_lock[0]  = 5'b00100; tbl_ret[0]  = 1'b0;
        tbl_req[1]  = 5'b00100; tbl_lock[1]  = 5'b00100; tbl_ret[1]  = 1'b0;
        tbl_req[2]  = 5'b00100; tbl_lock[2]  = 5'b00100; tbl_ret[2]  = 1'b0;
        tbl_req[3]  = 5'b00100; tbl_lock[3]  = 5'b00100; tbl_ret[3]  = 1'b0;
        tbl_req[4]  = 5'b00100; tbl_lock[4]  = 5'b00100; tbl_ret[4]  = 1'b1;
        tbl_req[5]  = 5'b11000; tbl_lock[5]  = 5'b01000; tbl_ret[5]  = 1'b1;
        tbl_req[6]  = 5'b11000; tbl_lock[6]  = 5'b01000; tbl_ret[6]  = 1'b1;
        tbl_req[7]  = 5'b11000; tbl_lock[7]  = 5'b00000; tbl_ret[7]  = 1'b1;
        tbl_req[8]  = 5'b00000; tbl_lock[8]  = 5'b00000; tbl_ret[8]  = 1'b1;
        tbl_req[9]  = 5'b10001; tbl_lock[9]  = 5'b10000; tbl_ret[9]  = 1'b0;
        tbl_req[10] = 5'b10001; tbl_lock[10] = 5'b10000; tbl_ret[10] = 1'b0;
        tbl_req[11] = 5'b01010; tbl_lock[11] = 5'b00000; tbl_ret[11] = 1'b1;
        for (int i = 0; i < 12; i++) tick(tbl_req[i], tbl_lock[i], tbl_ret[i]);
        tick(5'b0, 5'b0, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
